// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 timing constants and RGB565 colours shared by the vga_display stages
package vga_timing_pkg;

    typedef logic [9:0]  coord_t;
    typedef logic [15:0] rgb565_t;

    localparam int H_SYNC_DEF  = 96;
    localparam int H_BACK_DEF  = 48;
    localparam int H_DISP_DEF  = 640;
    localparam int H_FRONT_DEF = 16;
    localparam int V_SYNC_DEF  = 2;
    localparam int V_BACK_DEF  = 33;
    localparam int V_DISP_DEF  = 480;
    localparam int V_FRONT_DEF = 10;

    localparam int H_TOTAL = H_SYNC_DEF + H_BACK_DEF + H_DISP_DEF + H_FRONT_DEF;
    localparam int V_TOTAL = V_SYNC_DEF + V_BACK_DEF + V_DISP_DEF + V_FRONT_DEF;
    localparam int H_ACT   = H_SYNC_DEF + H_BACK_DEF;
    localparam int V_ACT   = V_SYNC_DEF + V_BACK_DEF;

    localparam rgb565_t BLACK = 16'h0000;
    localparam rgb565_t WHITE = 16'hFFFF;
    localparam rgb565_t RED   = 16'hF800;
    localparam rgb565_t GREEN = 16'h07E0;
    localparam rgb565_t BLUE  = 16'h001F;

endpackage

// File: rtl/vga_timing_gen_axis_counter.sv
// rtl/vga_timing_gen_axis_counter.sv - wrapping position counter for one raster axis
module vga_axis_counter #(
    parameter int TOTAL = 800,
    parameter int WIDTH = 10
) (
    input  logic             vga_clk,
    input  logic             sys_rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(TOTAL - 1);

    // wrap marks the edge on which this axis rolls over, so it can drive the next axis
    assign wrap = inc && (cnt == LAST);

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt <= '0;
        end else if (wrap) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator with one-cycle-early pixel coordinate requests
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_SYNC  = H_SYNC_DEF,
    parameter int H_BACK  = H_BACK_DEF,
    parameter int H_DISP  = H_DISP_DEF,
    parameter int H_FRONT = H_FRONT_DEF,
    parameter int V_SYNC  = V_SYNC_DEF,
    parameter int V_BACK  = V_BACK_DEF,
    parameter int V_DISP  = V_DISP_DEF,
    parameter int V_FRONT = V_FRONT_DEF
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic [15:0] pixel_data,
    output logic [9:0]  pixel_xpos,
    output logic [9:0]  pixel_ypos,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_de,
    output logic [15:0] vga_rgb,
    output logic        frame_start
);

    localparam int HTOT = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int VTOT = V_SYNC + V_BACK + V_DISP + V_FRONT;

    localparam coord_t HS_END = coord_t'(H_SYNC);
    localparam coord_t VS_END = coord_t'(V_SYNC);
    localparam coord_t HA_LO  = coord_t'(H_SYNC + H_BACK);
    localparam coord_t HA_HI  = coord_t'(H_SYNC + H_BACK + H_DISP);
    localparam coord_t HR_LO  = coord_t'(H_SYNC + H_BACK - 1);
    localparam coord_t HR_HI  = coord_t'(H_SYNC + H_BACK - 1 + H_DISP);
    localparam coord_t VA_LO  = coord_t'(V_SYNC + V_BACK);
    localparam coord_t VA_HI  = coord_t'(V_SYNC + V_BACK + V_DISP);

    coord_t h_cnt;
    coord_t v_cnt;
    logic   h_wrap;
    logic   v_wrap;
    logic   v_active;
    logic   pixel_req;

    vga_axis_counter #(.TOTAL(HTOT), .WIDTH(10)) u_h_counter (
        .vga_clk   (vga_clk),
        .sys_rst_n (sys_rst_n),
        .inc       (1'b1),
        .cnt       (h_cnt),
        .wrap      (h_wrap)
    );

    vga_axis_counter #(.TOTAL(VTOT), .WIDTH(10)) u_v_counter (
        .vga_clk   (vga_clk),
        .sys_rst_n (sys_rst_n),
        .inc       (h_wrap),
        .cnt       (v_cnt),
        .wrap      (v_wrap)
    );

    assign vga_hs   = (h_cnt >= HS_END);
    assign vga_vs   = (v_cnt >= VS_END);
    assign v_active = (v_cnt >= VA_LO) && (v_cnt < VA_HI);

    // Requests lead vga_de by one pixel to hide the display stage's register
    assign pixel_req  = v_active && (h_cnt >= HR_LO) && (h_cnt < HR_HI);
    assign vga_de     = v_active && (h_cnt >= HA_LO) && (h_cnt < HA_HI);
    assign pixel_xpos = pixel_req ? (h_cnt - HR_LO) : '0;
    assign pixel_ypos = pixel_req ? (v_cnt - VA_LO) : '0;
    assign vga_rgb    = vga_de ? pixel_data : BLACK;

    // v_wrap only fires on the last pixel of the last line, so the pulse lands on the wrapped (0,0)
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= v_wrap;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen against a raster-time reference model
module tb_vga_timing_gen;

    logic        vga_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [15:0] pd_a, pd_b;
    logic [9:0]  xpos_a, ypos_a, xpos_b, ypos_b;
    logic        hs_a, vs_a, de_a, fs_a, hs_b, vs_b, de_b, fs_b;
    logic [15:0] rgb_a, rgb_b;

    int n_tests = 0;
    int n_fail  = 0;
    int t;
    int de_cnt;

    typedef struct {
        bit hs, vs, de, fs;
        int x, y, dx;
    } exp_t;

    always #20 vga_clk = ~vga_clk;

    vga_timing_gen dut_a (
        .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .pixel_data(pd_a),
        .pixel_xpos(xpos_a), .pixel_ypos(ypos_a), .vga_hs(hs_a), .vga_vs(vs_a),
        .vga_de(de_a), .vga_rgb(rgb_a), .frame_start(fs_a)
    );

    vga_timing_gen #(
        .H_SYNC(4), .H_BACK(3), .H_DISP(10), .H_FRONT(2),
        .V_SYNC(2), .V_BACK(3), .V_DISP(6),  .V_FRONT(2)
    ) dut_b (
        .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .pixel_data(pd_b),
        .pixel_xpos(xpos_b), .pixel_ypos(ypos_b), .vga_hs(hs_b), .vga_vs(vs_b),
        .vga_de(de_b), .vga_rgb(rgb_b), .frame_start(fs_b)
    );

    // Outputs as a function of elapsed cycles since reset release
    function automatic exp_t model(input int hsw, hb, hd, hf, vsw, vb, vd, vf, input int tt);
        exp_t e;
        int htot = hsw + hb + hd + hf;
        int vtot = vsw + vb + vd + vf;
        int hact = hsw + hb;
        int vact = vsw + vb;
        int h = tt % htot;
        int v = (tt / htot) % vtot;
        bit vin = (v >= vact) && (v < vact + vd);
        bit req = vin && (h >= hact - 1) && (h < hact - 1 + hd);
        e.hs = (h >= hsw);
        e.vs = (v >= vsw);
        e.de = vin && (h >= hact) && (h < hact + hd);
        e.x  = req ? h - (hact - 1) : 0;
        e.y  = req ? v - vact : 0;
        e.dx = h - hact;
        e.fs = (tt > 0) && (tt % (htot * vtot) == 0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, expv);
        end
    endtask

    task automatic check_reset();
        chk("rst_a_hs", 32'(hs_a), 0);  chk("rst_a_vs", 32'(vs_a), 0);
        chk("rst_a_de", 32'(de_a), 0);  chk("rst_a_rgb", 32'(rgb_a), 0);
        chk("rst_a_fs", 32'(fs_a), 0);  chk("rst_a_x", 32'(xpos_a), 0);
        chk("rst_a_y", 32'(ypos_a), 0);
        chk("rst_b_hs", 32'(hs_b), 0);  chk("rst_b_vs", 32'(vs_b), 0);
        chk("rst_b_de", 32'(de_b), 0);  chk("rst_b_rgb", 32'(rgb_b), 0);
        chk("rst_b_fs", 32'(fs_b), 0);  chk("rst_b_x", 32'(xpos_b), 0);
        chk("rst_b_y", 32'(ypos_b), 0);
    endtask

    task automatic check_cycle();
        exp_t ea = model(96, 48, 640, 16, 2, 33, 480, 10, t);
        exp_t eb = model(4, 3, 10, 2, 2, 3, 6, 2, t);
        chk("a_hs", 32'(hs_a), 32'(ea.hs));
        chk("a_vs", 32'(vs_a), 32'(ea.vs));
        chk("a_de", 32'(de_a), 32'(ea.de));
        chk("a_x", 32'(xpos_a), 32'(ea.x));
        chk("a_y", 32'(ypos_a), 32'(ea.y));
        chk("a_fs", 32'(fs_a), 32'(ea.fs));
        chk("a_rgb_aligned", 32'(rgb_a), ea.de ? 32'(ea.dx) : 32'd0);
        chk("b_hs", 32'(hs_b), 32'(eb.hs));
        chk("b_vs", 32'(vs_b), 32'(eb.vs));
        chk("b_de", 32'(de_b), 32'(eb.de));
        chk("b_x", 32'(xpos_b), 32'(eb.x));
        chk("b_y", 32'(ypos_b), 32'(eb.y));
        chk("b_fs", 32'(fs_b), 32'(eb.fs));
        chk("b_rgb", 32'(rgb_b), eb.de ? 32'(pd_b) : 32'd0);
        if (eb.fs) begin
            chk("b_de_per_frame", de_cnt, 60);
            de_cnt = 0;
        end
        if (de_b === 1'b1) de_cnt++;
    endtask

    // Stub display stage for dut_a registers the requested column; dut_b gets random pixels
    task automatic advance();
        pd_a = {6'b0, xpos_a};
        pd_b = 16'($urandom);
        @(negedge vga_clk);
        t++;
    endtask

    initial begin
        t = 0;
        de_cnt = 0;
        pd_a = 16'hF800;
        pd_b = 16'hF800;
        repeat (10) @(negedge vga_clk);
        check_reset();

        sys_rst_n = 1'b1;
        for (int i = 0; i < 30000; i++) begin
            check_cycle();
            advance();
        end

        #5 sys_rst_n = 1'b0;
        #1 check_reset();
        pd_b = 16'hF800;
        repeat (3) @(negedge vga_clk);
        check_reset();

        sys_rst_n = 1'b1;
        t = 0;
        de_cnt = 0;
        for (int i = 0; i < 800; i++) begin
            check_cycle();
            advance();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
